inst_decode: RTL and testbench
==============================

Name: inst_decode

Overview:
- Decode stage directly downstream of instruction fetch in the RV64I in-order pipeline.
- Each posedge CLK, samples the fetched {PC, instruction} pair, reads the register file, and classifies the instruction.
- Generates the sign-extended immediate and loads an ID/EX pipeline register.
- Owns load-use hazard detection, drives the fetch stall, and inserts bubbles on branch flush.

Parameters:
- FLUSH_BUBBLES, 1, number of bubble cycles inserted after ex_take_branch (1..3).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low.
- if_inst  in  32  instruction from fetch; stable at posedge.
- if_pc  in  64  PC of if_inst.
- mem_stall  in  1  external memory stall; freezes the stage.
- ex_take_branch  in  1  branch/jump taken in EX; flushes the wrong-path instruction.
- rs1_addr  out  5  register-file read address; combinational = if_inst[19:15].
- rs2_addr  out  5  combinational = if_inst[24:20].
- rs1_data  in  64  register-file read data, same cycle.
- rs2_data  in  64  register-file read data, same cycle.
- stall_fetch  out  1  combinational; holds fetch PC/inst.
- id_valid  out  1  ID/EX register holds a real instruction.
- id_pc  out  64  PC of the decoded instruction.
- id_op_class  out  4  class code (see Decomposition).
- id_funct3  out  3  inst[14:12].
- id_funct7  out  7  inst[31:25].
- id_rd  out  5  destination register; forced to 0 for BRANCH and STORE.
- id_rs1  out  5  source 1 index.
- id_rs2  out  5  source 2 index.
- id_rs1_val  out  64  rs1 value; 0 if rs1==0.
- id_rs2_val  out  64  rs2 value; 0 if rs2==0.
- id_imm  out  64  sign-extended immediate; format selected by opcode.
- id_illegal  out  1  unknown opcode, or inst[1:0]!=2'b11.

Behaviour:
- Reset (async, any time): all outputs registered to 0, id_valid=0, id_op_class=NOP, state=RUN, flush counter=0. A reset mid-flush or mid-stall abandons that state.
- Latency: 1 cycle. The if_inst present at posedge N appears on id_* after posedge N.
- Priority at each posedge: mem_stall > flush > load-use > normal.
- mem_stall=1: all registers hold, including state and counter. ex_take_branch is ignored; EX keeps it asserted until the stall clears. stall_fetch=1.
- FSM, state RUN:
  - ex_take_branch=1: load a bubble; counter=FLUSH_BUBBLES-1; go to FLUSH if the counter is nonzero, else stay in RUN.
  - Load-use hazard: load a bubble; stall_fetch=1; stay in RUN. Next cycle fetch re-presents the same instruction, which now proceeds.
  - Otherwise: load the decoded instruction with id_valid=1.
- FSM, state FLUSH: load a bubble each cycle and decrement the counter; go to RUN when the counter reaches 0. A new ex_take_branch reloads the counter to FLUSH_BUBBLES-1. No hazard detection runs in FLUSH.
- Load-use hazard definition: id_valid & id_op_class==LOAD & id_rd!=0 & ((rs1_used & rs1_addr==id_rd) | (rs2_used & rs2_addr==id_rd)). Suppressed when ex_take_branch=1.
- rs1_used: every class except LUI, AUIPC, JAL, FENCE, NOP, ILLEGAL.
- rs2_used: BRANCH, STORE, OP, OP32.
- stall_fetch = mem_stall | hazard.
- Bubble contents: id_valid=0, op_class=NOP, all other fields 0.
- Immediates, all sign-extended from inst[31]:
  - I: inst[31:20]; used by OPIMM, OPIMM32, LOAD, JALR, SYSTEM.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}, then sign-extended to 64.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - OP, OP32, FENCE, ILLEGAL: 0.
- Illegal instruction: id_valid=1, op_class=ILLEGAL, id_illegal=1, id_rd=0. The trap is handled downstream.

Decomposition:
- Package inst_decode_pkg holds:
  - RV64I opcode constants.
  - op_class codes: NOP=0, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, OPIMM32, OP32, FENCE, SYSTEM, ILLEGAL.
  - FSM state encodings RUN and FLUSH.
- One combinational sub-module, imm_gen: inst[31:0] plus class -> 64-bit immediate.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093) at PC 0x0: after 1 posedge, id_valid=1, op_class=OPIMM, id_rd=1, id_imm=5, id_pc=0.
- beq x0,x0,-8 (0xFE000CE3): id_imm=0xFFFF_FFFF_FFFF_FFF8, id_rd=0, op_class=BRANCH.
- ld x2,0(x1) (0x0000B103) followed by add x3,x2,x2 (0x002101B3): stall_fetch=1 for exactly 1 cycle, one bubble (id_valid=0), then add appears with id_rd=3.
- ex_take_branch pulse with FLUSH_BUBBLES=2: id_valid=0 for 2 consecutive cycles, then the target instruction. With mem_stall=1 held 3 cycles, all id_* are unchanged.
- if_inst=0x00000000: id_illegal=1, op_class=ILLEGAL, id_valid=1. rs1=0 with rs1_data=0xDEAD gives id_rs1_val=0.
- Assert reset while in FLUSH or during a load-use stall: all outputs are 0 immediately (asynchronous); the first instruction after release decodes normally.

Source files
------------

// File: rtl/inst_decode_pkg.sv
// Shared types and constants for the RV64I decode stage.
package inst_decode_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned REG_AW = 5;

  // RV64I major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    OC_NOP     = 4'd0,
    OC_LUI     = 4'd1,
    OC_AUIPC   = 4'd2,
    OC_JAL     = 4'd3,
    OC_JALR    = 4'd4,
    OC_BRANCH  = 4'd5,
    OC_LOAD    = 4'd6,
    OC_STORE   = 4'd7,
    OC_OPIMM   = 4'd8,
    OC_OP      = 4'd9,
    OC_OPIMM32 = 4'd10,
    OC_OP32    = 4'd11,
    OC_FENCE   = 4'd12,
    OC_SYSTEM  = 4'd13,
    OC_ILLEGAL = 4'd14
  } op_class_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } dec_state_e;

  // ID/EX pipeline register payload
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    op_class_e         op_class;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic              illegal;
  } id_ex_t;

  // Map a raw instruction word onto its class; anything unrecognised is illegal.
  function automatic op_class_e classify(input logic [ILEN-1:0] inst);
    op_class_e c;
    c = OC_ILLEGAL;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        OPC_LUI:     c = OC_LUI;
        OPC_AUIPC:   c = OC_AUIPC;
        OPC_JAL:     c = OC_JAL;
        OPC_JALR:    c = OC_JALR;
        OPC_BRANCH:  c = OC_BRANCH;
        OPC_LOAD:    c = OC_LOAD;
        OPC_STORE:   c = OC_STORE;
        OPC_OPIMM:   c = OC_OPIMM;
        OPC_OP:      c = OC_OP;
        OPC_OPIMM32: c = OC_OPIMM32;
        OPC_OP32:    c = OC_OP32;
        OPC_FENCE:   c = OC_FENCE;
        OPC_SYSTEM:  c = OC_SYSTEM;
        default:     c = OC_ILLEGAL;
      endcase
    end
    return c;
  endfunction

  // True when the class actually reads rs1.
  function automatic logic rs1_used(input op_class_e c);
    logic u;
    case (c)
      OC_LUI, OC_AUIPC, OC_JAL, OC_FENCE, OC_NOP, OC_ILLEGAL: u = 1'b0;
      default: u = 1'b1;
    endcase
    return u;
  endfunction

  // True when the class actually reads rs2.
  function automatic logic rs2_used(input op_class_e c);
    logic u;
    case (c)
      OC_BRANCH, OC_STORE, OC_OP, OC_OP32: u = 1'b1;
      default: u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/inst_decode_imm_gen.sv
// Sign-extended immediate generator; format chosen by instruction class.
module inst_decode_imm_gen
  import inst_decode_pkg::*;
(
  input  logic [ILEN-1:7] i_inst,
  input  op_class_e       i_op_class,
  output logic [XLEN-1:0] o_imm_c
);

  // Select the immediate layout for the class; register-register forms yield 0.
  always_comb begin
    o_imm_c = '0;
    case (i_op_class)
      OC_OPIMM, OC_OPIMM32, OC_LOAD, OC_JALR, OC_SYSTEM:
        o_imm_c = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
      OC_STORE:
        o_imm_c = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      OC_BRANCH:
        o_imm_c = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7],
                   i_inst[30:25], i_inst[11:8], 1'b0};
      OC_LUI, OC_AUIPC:
        o_imm_c = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
      OC_JAL:
        o_imm_c = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12],
                   i_inst[20], i_inst[30:21], 1'b0};
      default:
        o_imm_c = '0;
    endcase
  end

endmodule

// File: rtl/inst_decode.sv
// RV64I decode stage: classify, read operands, build ID/EX, handle load-use and flush.
module inst_decode
  import inst_decode_pkg::*;
#(
  parameter int unsigned FLUSH_BUBBLES = 1
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [ILEN-1:0]     if_inst,
  input  logic [XLEN-1:0]     if_pc,
  input  logic                mem_stall,
  input  logic                ex_take_branch,
  output logic [REG_AW-1:0]   rs1_addr,
  output logic [REG_AW-1:0]   rs2_addr,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  output logic                stall_fetch,
  output logic                id_valid,
  output logic [XLEN-1:0]     id_pc,
  output logic [3:0]          id_op_class,
  output logic [2:0]          id_funct3,
  output logic [6:0]          id_funct7,
  output logic [REG_AW-1:0]   id_rd,
  output logic [REG_AW-1:0]   id_rs1,
  output logic [REG_AW-1:0]   id_rs2,
  output logic [XLEN-1:0]     id_rs1_val,
  output logic [XLEN-1:0]     id_rs2_val,
  output logic [XLEN-1:0]     id_imm,
  output logic                id_illegal
);

  localparam int unsigned     CNT_W      = 2;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_BUBBLES - 1);

  dec_state_e        r_state;
  dec_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  id_ex_t            r_id;
  id_ex_t            w_id_dec;
  logic              w_id_en;
  logic              w_id_bubble;
  logic              w_hazard;
  logic              w_rs1_hit;
  logic              w_rs2_hit;
  op_class_e         w_class;
  logic [XLEN-1:0]   w_imm;

  assign rs1_addr = if_inst[19:15];
  assign rs2_addr = if_inst[24:20];
  assign w_class  = classify(if_inst);

  inst_decode_imm_gen u_imm_gen (
    .i_inst     (if_inst[ILEN-1:7]),
    .i_op_class (w_class),
    .o_imm_c    (w_imm)
  );

  // Load-use detection against the load currently sitting in ID/EX; RUN only.
  assign w_rs1_hit = rs1_used(w_class) && (rs1_addr == r_id.rd);
  assign w_rs2_hit = rs2_used(w_class) && (rs2_addr == r_id.rd);
  assign w_hazard  = (r_state == ST_RUN) && !ex_take_branch && r_id.valid &&
                     (r_id.op_class == OC_LOAD) && (r_id.rd != '0) &&
                     (w_rs1_hit || w_rs2_hit);

  assign stall_fetch = mem_stall | w_hazard;

  // Build the decoded ID/EX payload for the instruction presented by fetch.
  always_comb begin
    w_id_dec          = '0;
    w_id_dec.valid    = 1'b1;
    w_id_dec.pc       = if_pc;
    w_id_dec.op_class = w_class;
    w_id_dec.funct3   = if_inst[14:12];
    w_id_dec.funct7   = if_inst[31:25];
    w_id_dec.rs1      = if_inst[19:15];
    w_id_dec.rs2      = if_inst[24:20];
    w_id_dec.rd       = if_inst[11:7];
    if ((w_class == OC_BRANCH) || (w_class == OC_STORE) || (w_class == OC_ILLEGAL)) begin
      w_id_dec.rd = '0;
    end
    w_id_dec.rs1_val  = (if_inst[19:15] == '0) ? '0 : rs1_data;
    w_id_dec.rs2_val  = (if_inst[24:20] == '0) ? '0 : rs2_data;
    w_id_dec.imm      = w_imm;
    w_id_dec.illegal  = (w_class == OC_ILLEGAL);
  end

  // Next-state logic: memory stall freezes everything, then flush, then load-use.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_id_en     = 1'b0;
    w_id_bubble = 1'b0;
    if (!mem_stall) begin
      w_id_en = 1'b1;
      case (r_state)
        ST_RUN: begin
          if (ex_take_branch) begin
            w_id_bubble = 1'b1;
            w_cnt_nxt   = CNT_RELOAD;
            w_state_nxt = (CNT_RELOAD != '0) ? ST_FLUSH : ST_RUN;
          end else if (w_hazard) begin
            w_id_bubble = 1'b1;
          end
        end
        ST_FLUSH: begin
          w_id_bubble = 1'b1;
          if (ex_take_branch) begin
            w_cnt_nxt   = CNT_RELOAD;
            w_state_nxt = (CNT_RELOAD != '0) ? ST_FLUSH : ST_RUN;
          end else if (r_cnt <= CNT_W'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RUN;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // FSM state and flush counter.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ID/EX pipeline register: hold, bubble, or load the decoded instruction.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_id <= '0;
    end else if (w_id_en) begin
      r_id <= w_id_bubble ? '0 : w_id_dec;
    end
  end

  assign id_valid    = r_id.valid;
  assign id_pc       = r_id.pc;
  assign id_op_class = r_id.op_class;
  assign id_funct3   = r_id.funct3;
  assign id_funct7   = r_id.funct7;
  assign id_rd       = r_id.rd;
  assign id_rs1      = r_id.rs1;
  assign id_rs2      = r_id.rs2;
  assign id_rs1_val  = r_id.rs1_val;
  assign id_rs2_val  = r_id.rs2_val;
  assign id_imm      = r_id.imm;
  assign id_illegal  = r_id.illegal;

endmodule

// File: tb/tb_inst_decode.sv
// Bench for inst_decode: directed plan items followed by a random run against a reference model.
module tb_inst_decode;

  localparam int unsigned FB = 2;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        mem_stall;
  logic        ex_take_branch;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rs1_data, rs2_data;
  logic        stall_fetch;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [3:0]  id_op_class;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [63:0] id_rs1_val, id_rs2_val, id_imm;
  logic        id_illegal;

  logic [63:0] regs [32];
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] v1;
    logic [63:0] v2;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  exp_t m;
  int   m_left;
  logic last_stall;
  logic obs_stall;

  always #5 CLK = ~CLK;

  assign rs1_data = regs[if_inst[19:15]];
  assign rs2_data = regs[if_inst[24:20]];

  inst_decode #(.FLUSH_BUBBLES(FB)) dut (
    .CLK(CLK), .reset(reset), .if_inst(if_inst), .if_pc(if_pc),
    .mem_stall(mem_stall), .ex_take_branch(ex_take_branch),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall_fetch(stall_fetch),
    .id_valid(id_valid), .id_pc(id_pc), .id_op_class(id_op_class),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_illegal(id_illegal)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Class numbering: NOP0 LUI1 AUIPC2 JAL3 JALR4 BRANCH5 LOAD6 STORE7 OPIMM8 OP9 OPIMM32 10 OP32 11 FENCE12 SYSTEM13 ILLEGAL14
  function automatic int cls_of(input logic [31:0] i);
    if (i[1:0] != 2'b11) return 14;
    case (i[6:2])
      5'b01101: return 1;
      5'b00101: return 2;
      5'b11011: return 3;
      5'b11001: return 4;
      5'b11000: return 5;
      5'b00000: return 6;
      5'b01000: return 7;
      5'b00100: return 8;
      5'b01100: return 9;
      5'b00110: return 10;
      5'b01110: return 11;
      5'b00011: return 12;
      5'b11100: return 13;
      default:  return 14;
    endcase
  endfunction

  function automatic logic uses1(input int c);
    return !(c == 0 || c == 1 || c == 2 || c == 3 || c == 12 || c == 14);
  endfunction

  function automatic logic uses2(input int c);
    return (c == 5 || c == 7 || c == 9 || c == 11);
  endfunction

  function automatic exp_t model_decode(input logic [31:0] i, input logic [63:0] pc,
                                        input logic [63:0] d1, input logic [63:0] d2);
    exp_t e;
    int c;
    c = cls_of(i);
    e       = '0;
    e.valid = 1'b1;
    e.pc    = pc;
    e.cls   = 4'(c);
    e.f3    = i[14:12];
    e.f7    = i[31:25];
    e.rs1   = i[19:15];
    e.rs2   = i[24:20];
    e.rd    = (c == 5 || c == 7 || c == 14) ? 5'd0 : i[11:7];
    e.v1    = (i[19:15] == 5'd0) ? 64'd0 : d1;
    e.v2    = (i[24:20] == 5'd0) ? 64'd0 : d2;
    e.ill   = (c == 14);
    case (c)
      4, 6, 8, 10, 13: e.imm = 64'($signed(i[31:20]));
      7:               e.imm = 64'($signed({i[31:25], i[11:7]}));
      5:               e.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      1, 2:            e.imm = 64'($signed({i[31:12], 12'h000}));
      3:               e.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default:         e.imm = 64'd0;
    endcase
    return e;
  endfunction

  function automatic logic model_hazard(input logic [31:0] i);
    int c;
    c = cls_of(i);
    if (!(m.valid && m.cls == 4'd6 && m.rd != 5'd0)) return 1'b0;
    return (uses1(c) && i[19:15] == m.rd) || (uses2(c) && i[24:20] == m.rd);
  endfunction

  task automatic check_regs();
    chk("id_valid",   64'(id_valid),    64'(m.valid));
    chk("id_pc",      id_pc,            m.pc);
    chk("id_class",   64'(id_op_class), 64'(m.cls));
    chk("id_funct3",  64'(id_funct3),   64'(m.f3));
    chk("id_funct7",  64'(id_funct7),   64'(m.f7));
    chk("id_rd",      64'(id_rd),       64'(m.rd));
    chk("id_rs1",     64'(id_rs1),      64'(m.rs1));
    chk("id_rs2",     64'(id_rs2),      64'(m.rs2));
    chk("id_rs1_val", id_rs1_val,       m.v1);
    chk("id_rs2_val", id_rs2_val,       m.v2);
    chk("id_imm",     id_imm,           m.imm);
    chk("id_illegal", 64'(id_illegal),  64'(m.ill));
  endtask

  task automatic drive(input logic [31:0] inst, input logic [63:0] pc,
                       input logic ms, input logic br);
    if_inst        = inst;
    if_pc          = pc;
    mem_stall      = ms;
    ex_take_branch = br;
  endtask

  // One clock: check combinational outputs, advance the model, check ID/EX after the edge.
  task automatic cycle();
    logic hz;
    logic exp_stall;
    #1;
    hz        = !ex_take_branch && (m_left == 0) && model_hazard(if_inst);
    exp_stall = mem_stall | hz;
    obs_stall = stall_fetch;
    chk("rs1_addr",    64'(rs1_addr),    64'(if_inst[19:15]));
    chk("rs2_addr",    64'(rs2_addr),    64'(if_inst[24:20]));
    chk("stall_fetch", 64'(stall_fetch), 64'(exp_stall));
    last_stall = exp_stall;
    if (!mem_stall) begin
      if (ex_take_branch) begin
        m = '0;
        m_left = int'(FB) - 1;
      end else if (m_left > 0) begin
        m = '0;
        m_left--;
      end else if (hz) begin
        m = '0;
      end else begin
        m = model_decode(if_inst, if_pc, rs1_data, rs2_data);
      end
    end
    @(posedge CLK);
    #1;
    check_regs();
  endtask

  // Pull reset between clock edges, check the clear is immediate, release after one edge.
  task automatic async_reset();
    #1;
    reset = 1'b0;
    #1;
    m = '0;
    m_left = 0;
    check_regs();
    chk("rst_stall", 64'(stall_fetch), 64'(mem_stall));
    @(posedge CLK);
    #1;
    reset = 1'b1;
  endtask

  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] BEQ_M8  = 32'hFE000CE3;
  localparam logic [31:0] LD_X2   = 32'h0000B103;
  localparam logic [31:0] ADD_X3  = 32'h002101B3;
  localparam logic [31:0] ADDI_X2 = 32'h00A00113;
  localparam logic [31:0] ADDI_X3 = 32'h00300193;

  logic [6:0]  opc_tab [13];
  logic [31:0] rnd;
  logic [63:0] rpc;
  logic        nbr;

  initial begin
    opc_tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0011011,
                7'b0111011, 7'b0001111, 7'b1110011};
    for (int k = 0; k < 32; k++) regs[k] = {$urandom(), $urandom()};
    m = '0;
    m_left = 0;
    last_stall = 1'b0;
    reset = 1'b0;
    drive(32'h0, 64'h0, 1'b0, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_regs();
    chk("reset_valid", 64'(id_valid), 64'd0);
    reset = 1'b1;

    // addi x1,x0,5 at PC 0
    drive(ADDI_X1, 64'h0, 1'b0, 1'b0);
    cycle();
    chk("addi_valid", 64'(id_valid),    64'd1);
    chk("addi_class", 64'(id_op_class), 64'd8);
    chk("addi_rd",    64'(id_rd),       64'd1);
    chk("addi_imm",   id_imm,           64'd5);
    chk("addi_pc",    id_pc,            64'd0);

    // beq x0,x0,-8
    drive(BEQ_M8, 64'h4, 1'b0, 1'b0);
    cycle();
    chk("beq_imm",   id_imm,           64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_rd",    64'(id_rd),       64'd0);
    chk("beq_class", 64'(id_op_class), 64'd5);

    // ld x2,0(x1) then add x3,x2,x2: one stall cycle, one bubble
    drive(LD_X2, 64'h8, 1'b0, 1'b0);
    cycle();
    drive(ADD_X3, 64'hC, 1'b0, 1'b0);
    cycle();
    chk("lu_stall1",  64'(obs_stall), 64'd1);
    chk("lu_bubble",  64'(id_valid),  64'd0);
    cycle();
    chk("lu_stall2",  64'(obs_stall), 64'd0);
    chk("lu_add_vld", 64'(id_valid),  64'd1);
    chk("lu_add_rd",  64'(id_rd),     64'd3);

    // taken branch: two bubbles, then the target
    drive(ADDI_X1, 64'h10, 1'b0, 1'b1);
    cycle();
    chk("fl_bub1", 64'(id_valid), 64'd0);
    drive(ADDI_X2, 64'h100, 1'b0, 1'b0);
    cycle();
    chk("fl_bub2", 64'(id_valid), 64'd0);
    cycle();
    chk("fl_tgt_vld", 64'(id_valid), 64'd1);
    chk("fl_tgt_pc",  id_pc,         64'h100);

    // memory stall for three cycles freezes ID/EX (branch ignored while stalled)
    drive(ADDI_X3, 64'h104, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      ex_take_branch = (k == 2);
      cycle();
      chk("ms_pc",    id_pc,            64'h100);
      chk("ms_rd",    64'(id_rd),       64'd2);
      chk("ms_stall", 64'(obs_stall),   64'd1);
    end
    drive(ADDI_X3, 64'h104, 1'b0, 1'b0);
    cycle();
    chk("ms_after_pc", id_pc, 64'h104);

    // all-zero word is illegal; rs1=x0 reads as 0 despite rs1_data
    regs[0] = 64'hDEAD;
    drive(32'h0, 64'h108, 1'b0, 1'b0);
    cycle();
    chk("ill_flag",  64'(id_illegal),  64'd1);
    chk("ill_class", 64'(id_op_class), 64'd14);
    chk("ill_valid", 64'(id_valid),    64'd1);
    chk("ill_rs1v",  id_rs1_val,       64'd0);

    // reset in the middle of a flush
    drive(ADDI_X1, 64'h10C, 1'b0, 1'b1);
    cycle();
    drive(ADDI_X2, 64'h200, 1'b0, 1'b0);
    async_reset();
    drive(ADDI_X1, 64'h300, 1'b0, 1'b0);
    cycle();
    chk("rstfl_vld", 64'(id_valid), 64'd1);
    chk("rstfl_pc",  id_pc,         64'h300);

    // reset during a load-use stall
    drive(LD_X2, 64'h304, 1'b0, 1'b0);
    cycle();
    drive(ADD_X3, 64'h308, 1'b0, 1'b0);
    #1;
    chk("rstlu_pre", 64'(stall_fetch), 64'd1);
    async_reset();
    cycle();
    chk("rstlu_vld", 64'(id_valid), 64'd1);
    chk("rstlu_rd",  64'(id_rd),    64'd3);

    // randomized traffic with a fetch model that honours stall_fetch
    rpc = 64'h1000;
    for (int n = 0; n < 500; n++) begin
      if (!last_stall) begin
        rnd = $urandom();
        if ($urandom_range(0, 9) != 0) begin
          rnd[6:0]   = opc_tab[$urandom_range(0, 12)];
          rnd[11:7]  = 5'($urandom_range(0, 3));
          rnd[19:15] = 5'($urandom_range(0, 3));
          rnd[24:20] = 5'($urandom_range(0, 3));
        end
        rpc = rpc + 64'd4;
        if ($urandom_range(0, 15) == 0) regs[$urandom_range(0, 3)] = {$urandom(), $urandom()};
      end else begin
        rnd = if_inst;
      end
      nbr = (mem_stall && ex_take_branch) ? 1'b1 : ($urandom_range(0, 9) == 0);
      drive(rnd, rpc, ($urandom_range(0, 6) == 0), nbr);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
